// File: rtl/mem_responder.sv
// mem_responder: line-wide main-memory model sitting behind the CPU's external
// memory port. Accepts one read or write at a time, completes it a fixed number
// of cycles later with a one-cycle mem_ack, and refuses to re-serve a request the
// requester has not yet dropped.
module mem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 128,
  parameter int LINE_BYTES  = 16,
  parameter int DEPTH_LINES = 4096,
  parameter int LATENCY     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              mem_ack,
  output logic              mem_busy
);

  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              rw_r;
  logic [IDX_W-1:0]  idx_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] data_out_r;
  logic              ack_r, ack_s;
  logic              busy_r, busy_s;
  logic              accept_s;
  logic              done_s;
  logic              commit_s;
  logic              load_s;
  logic [DATA_W-1:0] store_r [DEPTH_LINES];

  // Offset bits and upper address bits are deliberately ignored (lines alias).
  logic unused_addr_s;
  assign unused_addr_s = ^{mem_addr[ADDR_W-1:OFF_W+IDX_W], mem_addr[OFF_W-1:0]};

  // Next-state, countdown and completion decode for the request handshake.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    ack_s    = 1'b0;
    accept_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_enable) begin
          accept_s = 1'b1;
          cnt_s    = CNT_W'(LATENCY - 1);
          state_s  = ST_BUSY;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          done_s  = 1'b1;
          ack_s   = 1'b1;
          state_s = ST_ACK;
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (mem_enable) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (mem_enable) begin
          state_s = ST_HOLD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s   = (state_s == ST_BUSY) || (state_s == ST_ACK);
    commit_s = done_s & rw_r;
    load_s   = done_s & ~rw_r;
  end

  // Control registers, latched request and registered outputs; reset aborts any transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CNT_W{1'b0}};
      rw_r       <= 1'b0;
      idx_r      <= {IDX_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      data_out_r <= {DATA_W{1'b0}};
      ack_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
      if (accept_s) begin
        rw_r    <= mem_rw;
        idx_r   <= mem_addr[OFF_W +: IDX_W];
        wdata_r <= mem_data_in;
      end
      if (load_s) begin
        data_out_r <= store_r[idx_r];
      end
    end
  end

  // Backing store update on write completion; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      store_r[idx_r] <= wdata_r;
    end
  end

  assign mem_data_out = data_out_r;
  assign mem_ack      = ack_r;
  assign mem_busy     = busy_r;

endmodule
